// File: rtl/gate_counter_pkg.sv
// gate_counter_pkg: shared FSM state and count-event encodings for gate_counter.
//   gate_state_t : direction-mode gate sequence states
//   event_t      : per-cycle count operation (NONE, INC, DEC, CLR)
package gate_counter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_FIRST,
        B_FIRST,
        ENTERING,
        EXITING
    } gate_state_t;

    typedef enum logic [1:0] {
        NONE,
        INC,
        DEC,
        CLR
    } event_t;

endpackage

// File: rtl/gate_counter_input_debounce.sv
// input_debounce: 2-flop synchronizer plus stable-level debouncer with rise pulse.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_async        : raw asynchronous input
//   o_level        : debounced level, flips after DEBOUNCE_CYCLES stable cycles
//   o_rise         : one-cycle pulse in the cycle o_level goes high
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          w_done;
    assign w_done  = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign o_level = r_level;
    assign o_rise  = r_rise;
    // Counter tracks how long the synchronized input has disagreed with the debounced level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_async};
            r_rise <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/gate_counter.sv
// gate_counter: people counter driven by two light barriers, aux pulse lanes and buttons.
//   CLK, RST                : clock, asynchronous active-low reset
//   JB[3:0]                 : [0] barrier A, [1] barrier B, [3:2] auxiliary pulse lanes
//   switch                  : 0 = direction mode, 1 = tally mode
//   button_up/down/res      : manual +1, -1, clear
//   count, update, sat      : count value, change strobe, at-0-or-MAX_COUNT flag
// Optional: define GATE_COUNTER_TIMEOUT_EN to abort partial gate sequences after TIMEOUT_CYCLES.
module gate_counter
    import gate_counter_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int MAX_COUNT       = 255,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 200000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       JB,
    input  logic             switch,
    input  logic             button_up,
    input  logic             button_down,
    input  logic             button_res,
    output logic [WIDTH-1:0] count,
    output logic             update,
    output logic             sat
);
    if (MAX_COUNT > 2**WIDTH - 1 || MAX_COUNT < 1 || DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("gate_counter: illegal parameter combination");
    end
    localparam logic [WIDTH-1:0] MAXW = WIDTH'(MAX_COUNT);
    // Lane order: JB[3:0], switch, up, down, res.
    logic [7:0]       w_raw;
    logic [7:0]       w_lvl;
    logic [7:0]       w_rise;
    logic             w_a;
    logic             w_b;
    logic             w_tally;
    logic             w_mode_chg;
    logic             w_timeout;
    logic             r_mode_prev;
    gate_state_t      r_state;
    gate_state_t      w_state_nxt;
    event_t           w_gate_ev;
    event_t           w_ev;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_update;
    assign w_raw = {button_res, button_down, button_up, switch, JB};
    for (genvar g = 0; g < 8; g++) begin : g_deb
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .i_clk   (CLK),
            .i_rst_n (RST),
            .i_async (w_raw[g]),
            .o_level (w_lvl[g]),
            .o_rise  (w_rise[g])
        );
    end
    assign w_a        = w_lvl[0];
    assign w_b        = w_lvl[1];
    assign w_tally    = w_lvl[4];
    assign w_mode_chg = w_tally ^ r_mode_prev;
`ifdef GATE_COUNTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_timer;
    // Timer counts cycles spent in the current non-IDLE state; restarts on every transition.
    assign w_timeout = (r_state != IDLE) && (r_timer == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_timer <= '0;
        else r_timer <= (w_state_nxt != r_state || r_state == IDLE) ? '0 : r_timer + TW'(1);
    end
`else
    assign w_timeout = 1'b0;
`endif
    always_comb begin
        w_state_nxt = r_state;
        w_gate_ev   = NONE;
        if (w_mode_chg || w_tally || w_timeout) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:     w_state_nxt = (w_a && !w_b) ? A_FIRST : (w_b && !w_a) ? B_FIRST : IDLE;
                A_FIRST:  w_state_nxt = w_b ? ENTERING : !w_a ? IDLE : A_FIRST;
                B_FIRST:  w_state_nxt = w_a ? EXITING : !w_b ? IDLE : B_FIRST;
                ENTERING: begin
                    w_state_nxt = (!w_a && !w_b) ? IDLE : ENTERING;
                    w_gate_ev   = (!w_a && !w_b) ? INC : NONE;
                end
                EXITING:  begin
                    w_state_nxt = (!w_a && !w_b) ? IDLE : EXITING;
                    w_gate_ev   = (!w_a && !w_b) ? DEC : NONE;
                end
                default:  w_state_nxt = IDLE;
            endcase
        end
        // Tally: any lane edge gives a single +1, however many lanes fire together.
        if (w_tally && |w_rise[3:0]) w_gate_ev = INC;
    end
    assign w_ev = w_rise[7] ? CLR :
                  (w_gate_ev != NONE) ? w_gate_ev :
                  w_rise[5] ? INC :
                  w_rise[6] ? DEC : NONE;
    assign w_count_nxt = (w_ev == CLR) ? '0 :
                         (w_ev == INC && r_count != MAXW) ? r_count + WIDTH'(1) :
                         (w_ev == DEC && r_count != '0) ? r_count - WIDTH'(1) : r_count;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_mode_prev <= 1'b0;
            r_count     <= '0;
            r_update    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode_prev <= w_tally;
            r_count     <= w_count_nxt;
            r_update    <= (w_count_nxt != r_count);
        end
    end
    assign count  = r_count;
    assign update = r_update;
    assign sat    = (r_count == '0) || (r_count == MAXW);
endmodule

// File: tb/tb_gate_counter.sv
// tb_gate_counter: directed self-checking bench for gate_counter (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_gate_counter;
    import gate_counter_pkg::*;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] in_v = '0;
    logic [7:0] count;
    logic       update;
    logic       sat;
    int         n_chk = 0;
    int         n_bad = 0;
    int         n_upd = 0;
    int         upd0;
    int         streak;
    int         max_streak;
    gate_counter #(
        .WIDTH(8), .MAX_COUNT(255), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .JB          (in_v[3:0]),
        .switch      (in_v[4]),
        .button_up   (in_v[5]),
        .button_down (in_v[6]),
        .button_res  (in_v[7]),
        .count       (count),
        .update      (update),
        .sat         (sat)
    );
    always #5 CLK = ~CLK;
    always @(negedge CLK) if (update) n_upd++;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask
    task automatic press(input int k);
        in_v[k] = 1'b1;
        cyc(10);
        in_v[k] = 1'b0;
        cyc(10);
    endtask
    initial begin
        cyc(3);
        chk("rst_count", 32'(count), 0);
        chk("rst_update", 32'(update), 0);
        chk("rst_sat", 32'(sat), 1);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        RST = 1'b1;
        cyc(2);
        upd0 = n_upd;
        in_v[0] = 1'b1; cyc(10);
        in_v[1] = 1'b1; cyc(10);
        in_v[1:0] = 2'b00; cyc(10);
        chk("enter_count", 32'(count), 1);
        chk("enter_upd", 32'(n_upd - upd0), 1);
        repeat (4) press(5);
        chk("up_to_5", 32'(count), 5);
        in_v[1] = 1'b1; cyc(10);
        in_v[0] = 1'b1; cyc(10);
        in_v[1:0] = 2'b00; cyc(10);
        chk("exit_count", 32'(count), 4);
        press(0);
        chk("backout_a", 32'(count), 4);
        press(7);
        chk("res_count", 32'(count), 0);
        upd0 = n_upd;
        press(7);
        chk("res_at0_upd", 32'(n_upd - upd0), 0);
        repeat (255) press(5);
        chk("up_255", 32'(count), 255);
        chk("sat_max", 32'(sat), 1);
        upd0 = n_upd;
        repeat (5) press(5);
        chk("sat_hold", 32'(count), 255);
        chk("sat_no_upd", 32'(n_upd - upd0), 0);
        press(7);
        upd0 = n_upd;
        press(6);
        chk("down_at0", 32'(count), 0);
        chk("down_at0_upd", 32'(n_upd - upd0), 0);
        repeat (7) press(5);
        chk("up_to_7", 32'(count), 7);
        in_v[0] = 1'b1; cyc(10);
        in_v[1] = 1'b1; cyc(10);
        upd0 = n_upd;
        in_v[1:0] = 2'b00;
        in_v[7] = 1'b1; cyc(10);
        in_v[7] = 1'b0; cyc(10);
        chk("res_vs_gate", 32'(count), 0);
        chk("res_vs_gate_upd", 32'(n_upd - upd0), 1);
        repeat (10) press(5);
        chk("up_to_10", 32'(count), 10);
        in_v[4] = 1'b1; cyc(10);
        in_v[3:2] = 2'b11; cyc(10);
        in_v[3:2] = 2'b00; cyc(10);
        chk("tally_dual", 32'(count), 11);
        press(0);
        chk("tally_a", 32'(count), 12);
        chk("tally_state", 32'(dut.r_state), 32'(IDLE));
        in_v[4] = 1'b0; cyc(10);
        in_v[0] = 1'b1; cyc(10);
        in_v[1] = 1'b1; cyc(10);
        chk("mid_enter_state", 32'(dut.r_state), 32'(ENTERING));
        RST = 1'b0; cyc(2);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_state", 32'(dut.r_state), 32'(IDLE));
        chk("mid_rst_sat", 32'(sat), 1);
        RST = 1'b1; cyc(20);
        chk("both_rise_state", 32'(dut.r_state), 32'(IDLE));
        in_v[1:0] = 2'b00; cyc(20);
        chk("post_rst_count", 32'(count), 0);
        streak = 0;
        max_streak = 0;
        in_v[0] = 1'b1;
        repeat (90) begin
            @(negedge CLK);
            streak = (dut.r_state == A_FIRST) ? streak + 1 : 0;
            if (streak > max_streak) max_streak = streak;
        end
        in_v[0] = 1'b0; cyc(10);
        chk("hold_a_count", 32'(count), 0);
        chk("hold_a_state", 32'(dut.r_state), 32'(IDLE));
`ifdef GATE_COUNTER_TIMEOUT_EN
        chk("timeout_streak", 32'(max_streak), 50);
`else
        chk("no_timeout_streak", 32'(max_streak >= 60), 1);
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
